olive_std_core_nios2_fast_cpu_div_cell: RTL and testbench

Multi-cycle 32-bit integer divider for the Nios II fast core, covering DIV and DIVU. It is the inverse counterpart of the core's multiply cell. Operands come from the E-stage source buses. The block iterates one quotient bit per clock and presents a registered quotient and remainder with a one-cycle done pulse, while the core stalls on busy.

---
 rtl/olive_std_core_nios2_fast_cpu_div_cell.sv | 102 ++++++++++
 tb/tb_olive_std_core_nios2_fast_cpu_div_cell.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/olive_std_core_nios2_fast_cpu_div_cell.sv
// Restoring 32-bit DIV/DIVU cell: one quotient bit per clock, fixed 34-cycle issue-to-issue.
// Start edge k, 32 RUN edges, sign fix-up registered on edge k+33; core stalls on div_busy.
module olive_std_core_nios2_fast_cpu_div_cell (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] E_src1,
  input  logic [31:0] E_src2,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic        div_flush,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] div_quot,
  output logic [31:0] div_rem
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [32:0] part_rem;
  logic [31:0] dvd;
  logic [31:0] dsr;
  logic        sign_q;
  logic        sign_r;

  logic        neg1;
  logic        neg2;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [33:0] shifted;
  logic [33:0] trial;
  logic        take;

  // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
  assign neg1 = div_signed & E_src1[31];
  assign neg2 = div_signed & E_src2[31];
  assign mag1 = neg1 ? (32'd0 - E_src1) : E_src1;
  assign mag2 = neg2 ? (32'd0 - E_src2) : E_src2;

  // dvd doubles as the quotient shift register: dividend bits leave the top,
  // quotient bits enter the bottom.
  assign shifted = {part_rem, dvd[31]};
  assign trial   = shifted - {2'b00, dsr};
  assign take    = ~trial[33];

  assign div_busy = (state == RUN) || (state == FIX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      part_rem <= 33'd0;
      dvd      <= 32'd0;
      dsr      <= 32'd0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_done <= 1'b0;
      div_quot <= 32'd0;
      div_rem  <= 32'd0;
    end else begin
      div_done <= 1'b0;
      case (state)
        IDLE: begin
          if (div_start && !div_flush) begin
            sign_q   <= neg1 ^ neg2;
            sign_r   <= neg1;
            dvd      <= mag1;
            dsr      <= mag2;
            part_rem <= 33'd0;
            cnt      <= 5'd0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (div_flush) begin
            state <= IDLE;
          end else begin
            part_rem <= take ? trial[32:0] : shifted[32:0];
            dvd      <= {dvd[30:0], take};
            cnt      <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          state <= IDLE;
          if (!div_flush) begin
            div_quot <= sign_q ? (32'd0 - dvd) : dvd;
            div_rem  <= sign_r ? (32'd0 - part_rem[31:0]) : part_rem[31:0];
            div_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_olive_std_core_nios2_fast_cpu_div_cell.sv
// Bench for the divider cell: directed cases, flush/reset/busy-start cases and
// a back-to-back random regression against an arithmetic reference model.
module tb_olive_std_core_nios2_fast_cpu_div_cell;

  logic        clk;
  logic        reset_n;
  logic [31:0] E_src1;
  logic [31:0] E_src2;
  logic        div_start;
  logic        div_signed;
  logic        div_flush;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;

  int checks = 0;
  int errors = 0;

  olive_std_core_nios2_fast_cpu_div_cell dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .E_src1     (E_src1),
    .E_src2     (E_src2),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_flush  (div_flush),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_quot   (div_quot),
    .div_rem    (div_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Truncating division; remainder follows the dividend; divide-by-zero defined.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r);
    longint na, nb, lq, lr;
    if (b == 32'd0) begin
      q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else begin
      na = s ? longint'($signed(a)) : longint'({32'd0, a});
      nb = s ? longint'($signed(b)) : longint'({32'd0, b});
      lq = na / nb;
      lr = na % nb;
      q  = lq[31:0];
      r  = lr[31:0];
    end
  endtask

  // Called at a negedge; returns at the negedge where div_done is seen.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input int pulse_at);
    logic [31:0] eq, er;
    int lat, busy_cnt;
    bit found;
    logic busy_at_done;
    model(a, b, s, eq, er);
    E_src1 = a; E_src2 = b; div_signed = s; div_start = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    E_src1 = $urandom; E_src2 = $urandom; div_signed = $urandom_range(0, 1);
    found = 0; lat = 0; busy_cnt = 0; busy_at_done = 1'bx;
    for (int i = 1; i <= 40 && !found; i++) begin
      @(negedge clk);
      if (div_done) begin
        found = 1; lat = i; busy_at_done = div_busy;
      end else begin
        if (div_busy) busy_cnt++;
        if (i == pulse_at) begin
          E_src1 = $urandom; E_src2 = $urandom | 32'd1; div_start = 1'b1;
        end else begin
          div_start = 1'b0;
        end
      end
    end
    div_start = 1'b0;
    chk({tag, ".done_seen"}, 32'(found), 32'd1);
    chk({tag, ".latency"}, lat, 34);
    chk({tag, ".busy_cycles"}, busy_cnt, 33);
    chk({tag, ".busy_at_done"}, 32'(busy_at_done), 32'd0);
    chk({tag, ".quot"}, div_quot, eq);
    chk({tag, ".rem"}, div_rem, er);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 32'd0;
      1: pick = 32'd1;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'h8000_0000;
      4: pick = 32'h7FFF_FFFF;
      5: pick = 32'($urandom_range(0, 300));
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    int dn;
    reset_n = 1'b0; E_src1 = 0; E_src2 = 0;
    div_start = 0; div_signed = 0; div_flush = 0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(div_busy), 32'd0);
    chk("rst.done", 32'(div_done), 32'd0);
    chk("rst.quot", div_quot, 32'd0);
    chk("rst.rem", div_rem, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    do_op("divu_100_7", 32'd100, 32'd7, 1'b0, 0);
    chk("divu_100_7.q_const", div_quot, 32'd14);
    chk("divu_100_7.r_const", div_rem, 32'd2);
    do_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    chk("div_m7_2.q_const", div_quot, 32'hFFFF_FFFD);
    chk("div_m7_2.r_const", div_rem, 32'hFFFF_FFFF);
    do_op("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    chk("div_7_m2.q_const", div_quot, 32'hFFFF_FFFD);
    chk("div_7_m2.r_const", div_rem, 32'd1);
    do_op("divu_5_0", 32'd5, 32'd0, 1'b0, 0);
    chk("divu_5_0.q_const", div_quot, 32'hFFFF_FFFF);
    do_op("div_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 0);
    chk("div_m5_0.q_const", div_quot, 32'd1);
    chk("div_m5_0.r_const", div_rem, 32'hFFFF_FFFB);
    do_op("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    chk("div_min_m1.q_const", div_quot, 32'h8000_0000);
    do_op("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    chk("divu_max_1.q_const", div_quot, 32'hFFFF_FFFF);

    // Flush at edge k+10 of a running op; previous result must survive.
    do_op("pre_flush", 32'd100, 32'd7, 1'b0, 0);
    E_src1 = 32'd1000; E_src2 = 32'd3; div_signed = 1'b0; div_start = 1'b1;
    @(posedge clk);
    #1 div_start = 1'b0;
    dn = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      dn += int'(div_done);
    end
    div_flush = 1'b1;
    @(negedge clk);
    div_flush = 1'b0;
    dn += int'(div_done);
    chk("flush.busy_dropped", 32'(div_busy), 32'd0);
    chk("flush.no_done", dn, 0);
    chk("flush.quot_held", div_quot, 32'd14);
    chk("flush.rem_held", div_rem, 32'd2);
    do_op("after_flush", 32'd1000, 32'd3, 1'b0, 0);

    // Flush together with start in IDLE: nothing starts.
    E_src1 = 32'd50; E_src2 = 32'd5; div_start = 1'b1; div_flush = 1'b1;
    @(negedge clk);
    div_start = 1'b0; div_flush = 1'b0;
    chk("idle_flush.busy", 32'(div_busy), 32'd0);
    dn = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      dn += int'(div_done) + int'(div_busy);
    end
    chk("idle_flush.quiet", dn, 0);

    do_op("start_mid_run", 32'd12345, 32'd67, 1'b0, 15);

    // Asynchronous reset in the middle of an operation.
    E_src1 = 32'd777; E_src2 = 32'd5; div_signed = 1'b0; div_start = 1'b1;
    @(posedge clk);
    #1 div_start = 1'b0;
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.busy", 32'(div_busy), 32'd0);
    chk("arst.done", 32'(div_done), 32'd0);
    chk("arst.quot", div_quot, 32'd0);
    chk("arst.rem", div_rem, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_op("divu_9_3", 32'd9, 32'd3, 1'b0, 0);

    // Back-to-back random regression, each start issued in the done cycle.
    for (int n = 0; n < 2000; n++) begin
      do_op("rand", pick(), pick(), 1'(($urandom_range(0, 1))), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
